button_conditioner: RTL and testbench



---
 rtl/button_conditioner_pkg.sv | 25 ++
 rtl/button_debounce_ch.sv | 88 ++++++++
 rtl/button_conditioner.sv | 55 +++++
 tb/tb_button_conditioner.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared constants and types for the push-button front-end.
// Timing defaults assume a 100 MHz system clock.
package button_conditioner_pkg;

    localparam int N_BTN = 4;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    localparam int DEBOUNCE_20MS = 2_000_000;
    localparam int REPEAT_500MS  = 50_000_000;
    localparam int REPEAT_150MS  = 15_000_000;

    typedef enum logic {
        PH_DELAY  = 1'b0,
        PH_PERIOD = 1'b1
    } rep_phase_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce counter and optional
// auto-repeat timer. The press/repeat pulse is combinational; the top registers it.
module button_debounce_ch
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int REPEAT_DELAY    = REPEAT_500MS,
    parameter int REPEAT_PERIOD   = REPEAT_150MS,
    parameter bit REPEAT_ENABLE   = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic btn_raw,
    output logic press_pulse,
    output logic btn_level
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [DW-1:0] DCNT_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [1:0]    sync_q, sync_d;
    logic          lvl_q, lvl_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    rep_phase_e    phase_q, phase_d;
    logic          s;

    always_comb begin
        sync_d      = {sync_q[0], btn_raw};
        s           = sync_q[1];
        lvl_d       = lvl_q;
        dcnt_d      = dcnt_q;
        rcnt_d      = rcnt_q;
        phase_d     = phase_q;
        press_pulse = 1'b0;

        // Any sample matching the accepted level restarts the stability count.
        if (s == lvl_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DCNT_LAST) begin
            lvl_d  = s;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end

        if (lvl_d && !lvl_q) begin
            press_pulse = 1'b1;
            rcnt_d      = '0;
            phase_d     = PH_DELAY;
        end else if (!lvl_d) begin
            // Idle or just released: the repeat timer stays parked.
            rcnt_d  = '0;
            phase_d = PH_DELAY;
        end else if (REPEAT_ENABLE) begin
            if (rcnt_q == ((phase_q == PH_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                press_pulse = 1'b1;
                rcnt_d      = '0;
                phase_d     = PH_PERIOD;
            end else begin
                rcnt_d = rcnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q  <= '0;
            lvl_q   <= 1'b0;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
            phase_q <= PH_DELAY;
        end else begin
            sync_q  <= sync_d;
            lvl_q   <= lvl_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
            phase_q <= phase_d;
        end
    end

    assign btn_level = lvl_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front-end for the menu FSM: N_BTN independent debounced channels
// with gated, registered single-cycle press/repeat pulses.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int                           N_BTN           = button_conditioner_pkg::N_BTN,
    parameter int                           DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter logic [N_BTN-1:0]             REPEAT_EN       = 4'b0011,
    parameter int                           REPEAT_DELAY    = REPEAT_500MS,
    parameter int                           REPEAT_PERIOD   = REPEAT_150MS
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             enable,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_level
);

    logic [N_BTN-1:0] ch_pulse;
    logic [N_BTN-1:0] btn_pulse_q, btn_pulse_d;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
            button_debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD),
                .REPEAT_ENABLE   (REPEAT_EN[gi])
            ) u_ch (
                .sys_clk     (sys_clk),
                .sys_rst_n   (sys_rst_n),
                .btn_raw     (btn_raw[gi]),
                .press_pulse (ch_pulse[gi]),
                .btn_level   (btn_level[gi])
            );
        end
    endgenerate

    // A pulse blocked by enable is simply lost; repeat timing keeps running.
    always_comb begin
        btn_pulse_d = ch_pulse & {N_BTN{enable}};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            btn_pulse_q <= '0;
        end else begin
            btn_pulse_q <= btn_pulse_d;
        end
    end

    assign btn_pulse = btn_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short debounce/repeat timing.
// Expected outputs come from a sample-history reference model fed to a scoreboard queue.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam logic [3:0] REN = 4'b0011;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       enable;
    logic [3:0] btn_raw;
    logic [3:0] btn_pulse;
    logic [3:0] btn_level;

    always #5 sys_clk = ~sys_clk;

    button_conditioner #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_EN       (REN),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .btn_raw   (btn_raw),
        .enable    (enable),
        .btn_pulse (btn_pulse),
        .btn_level (btn_level)
    );

    typedef struct packed {
        logic [3:0] pulse;
        logic [3:0] level;
    } exp_t;

    typedef struct {
        string      name;
        logic [3:0] raw;
        logic       en;
        int         cycles;
        logic [3:0] exp_level;
        int         exp_pulses;
    } seg_t;

    exp_t       exp_q[$];
    seg_t       seg_q[$];
    logic [3:0] hist [0:DB+1];
    logic [3:0] lvl_m;
    int         press_t [4];
    int         edge_n;
    int         seg_pulses;
    int         n_vec;
    int         n_err;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m <= DB + 1; m++) hist[m] = 4'b0000;
        for (int i = 0; i < 4; i++) press_t[i] = 0;
        lvl_m  = 4'b0000;
        edge_n = 0;
        exp_q.delete();
    endtask

    // Level flips once the last DB synchronised samples (raw samples 2..DB+1 edges old)
    // all disagree with it; repeats fall at RD, RD+RP, ... edges after the press.
    task automatic model_edge(input logic [3:0] raw, input logic en);
        exp_t e;
        logic flip;
        logic ip;
        edge_n++;
        for (int m = DB + 1; m > 0; m--) hist[m] = hist[m-1];
        hist[0] = raw;
        for (int i = 0; i < 4; i++) begin
            flip = 1'b1;
            for (int m = 2; m <= DB + 1; m++) begin
                if (hist[m][i] == lvl_m[i]) flip = 1'b0;
            end
            ip = 1'b0;
            if (flip) begin
                lvl_m[i] = ~lvl_m[i];
                if (lvl_m[i]) begin
                    ip         = 1'b1;
                    press_t[i] = edge_n;
                end
            end else if (lvl_m[i] && REN[i] && (edge_n - press_t[i]) >= RD
                         && ((edge_n - press_t[i] - RD) % RP) == 0) begin
                ip = 1'b1;
            end
            e.pulse[i] = ip & en;
        end
        e.level = lvl_m;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty at edge %0d: got no expectation, expected one", edge_n);
        end else begin
            e = exp_q.pop_front();
            cmp("btn_pulse", {28'b0, btn_pulse}, {28'b0, e.pulse});
            cmp("btn_level", {28'b0, btn_level}, {28'b0, e.level});
        end
        seg_pulses += $countones(btn_pulse);
    endtask

    task automatic step(input logic [3:0] raw, input logic en);
        btn_raw = raw;
        enable  = en;
        @(posedge sys_clk);
        model_edge(raw, en);
        @(negedge sys_clk);
        check_out();
    endtask

    task automatic run_seg(input seg_t s);
        seg_pulses = 0;
        for (int c = 0; c < s.cycles; c++) step(s.raw, s.en);
        cmp({s.name, "_level"}, {28'b0, btn_level}, {28'b0, s.exp_level});
        cmp({s.name, "_pulses"}, seg_pulses, s.exp_pulses);
        $display("seg %-12s raw=%b en=%b cycles=%0d level=%b pulses=%0d",
                 s.name, s.raw, s.en, s.cycles, btn_level, seg_pulses);
    endtask

    task automatic add(input string name, input logic [3:0] raw, input logic en,
                       input int cycles, input logic [3:0] lvl, input int np);
        seg_t s;
        s.name = name; s.raw = raw; s.en = en; s.cycles = cycles;
        s.exp_level = lvl; s.exp_pulses = np;
        seg_q.push_back(s);
    endtask

    // Called at a falling edge: reset lands mid-cycle, outputs must clear without a clock.
    task automatic async_reset_check(input string name);
        #2 sys_rst_n = 1'b0;
        #1;
        cmp({name, "_pulse"}, {28'b0, btn_pulse}, 32'd0);
        cmp({name, "_level"}, {28'b0, btn_level}, 32'd0);
        model_clear();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        $display("reset %s applied and released", name);
    endtask

    task automatic run_hand(input string name, input logic [3:0] raw, input int cycles,
                            input logic [3:0] lvl, input int np);
        seg_t s;
        s.name = name; s.raw = raw; s.en = 1'b1; s.cycles = cycles;
        s.exp_level = lvl; s.exp_pulses = np;
        run_seg(s);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        sys_rst_n = 1'b0;
        btn_raw   = 4'b0000;
        enable    = 1'b1;
        model_clear();
        repeat (3) @(negedge sys_clk);
        cmp("reset_pulse", {28'b0, btn_pulse}, 32'd0);
        cmp("reset_level", {28'b0, btn_level}, 32'd0);
        sys_rst_n = 1'b1;

        add("idle",        4'b0000, 1'b1,  4, 4'b0000, 0);
        add("right_press", 4'b1000, 1'b1,  8, 4'b1000, 1);
        add("right_rel",   4'b0000, 1'b1,  8, 4'b0000, 0);
        add("bounce_a",    4'b0100, 1'b1,  1, 4'b0000, 0);
        add("bounce_b",    4'b0000, 1'b1,  1, 4'b0000, 0);
        add("bounce_c",    4'b0100, 1'b1,  1, 4'b0000, 0);
        add("bounce_d",    4'b0000, 1'b1,  1, 4'b0000, 0);
        add("left_hold",   4'b0100, 1'b1,  8, 4'b0100, 1);
        add("left_rel",    4'b0000, 1'b1,  8, 4'b0000, 0);
        add("down_hold",   4'b0010, 1'b1, 30, 4'b0010, 6);
        add("down_rel",    4'b0000, 1'b1,  8, 4'b0000, 2);
        add("up_right",    4'b1001, 1'b1, 17, 4'b1001, 3);
        add("up_right_rel",4'b0000, 1'b1,  8, 4'b0000, 2);
        add("up_pre",      4'b0001, 1'b1,  4, 4'b0000, 0);
        add("up_gated",    4'b0001, 1'b0,  3, 4'b0001, 0);
        add("up_ungated",  4'b0001, 1'b1, 10, 4'b0001, 1);
        add("up_rel",      4'b0000, 1'b1,  8, 4'b0000, 2);

        foreach (seg_q[k]) run_seg(seg_q[k]);

        // Reset while the left debounce count is part-way through.
        run_hand("left_part",  4'b0100,  4, 4'b0000, 0);
        async_reset_check("rst_mid_debounce");
        run_hand("left_after", 4'b0100,  8, 4'b0100, 1);
        run_hand("left_off",   4'b0000,  8, 4'b0000, 0);

        // Reset during the cycle a repeat pulse is high on down.
        run_hand("down_rep",   4'b0010, 16, 4'b0010, 2);
        cmp("repeat_pulse_high", {28'b0, btn_pulse}, 32'd2);
        async_reset_check("rst_mid_repeat");
        run_hand("down_after", 4'b0010,  8, 4'b0010, 1);
        run_hand("down_off",   4'b0000,  8, 4'b0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
